// File: rtl/reg_alu_seq_pkg.sv
// rtl/reg_alu_seq_pkg.sv - shared types and field positions for the reg_alu instruction sequencer
//
// Purpose: instruction class encodings, sequencer state enum, instruction
// field bit positions and a small class helper, shared by the decoder and
// the sequencer top.
// Ports: none (package).

package reg_alu_seq_pkg;

  // Instruction class, taken from instr[15:14].
  typedef enum logic [1:0] {
    CLS_LOADI = 2'b00,
    CLS_ALU   = 2'b01,
    CLS_NOP   = 2'b10,
    CLS_HALT  = 2'b11
  } cls_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HALT = 2'd2
  } state_e;

  // Widths matching reg_alu.
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int OP_W   = 2;
  localparam int INSN_W = 16;

  // Class field.
  localparam int CLS_MSB      = 15;
  localparam int CLS_LSB      = 14;

  // LOADI fields.
  localparam int LOADI_RD_MSB = 13;
  localparam int LOADI_RD_LSB = 11;
  localparam int IMM_MSB      = 7;
  localparam int IMM_LSB      = 0;

  // ALU fields.
  localparam int ALU_OP_MSB   = 13;
  localparam int ALU_OP_LSB   = 12;
  localparam int ALU_RD_MSB   = 11;
  localparam int ALU_RD_LSB   = 9;
  localparam int ALU_RA_MSB   = 8;
  localparam int ALU_RA_LSB   = 6;
  localparam int ALU_RB_MSB   = 5;
  localparam int ALU_RB_LSB   = 3;

  // Classes that write the register file during EXEC.
  function automatic logic cls_writes(input cls_e c);
    return (c == CLS_LOADI) || (c == CLS_ALU);
  endfunction

endpackage

// File: rtl/reg_alu_seq_decode.sv
// rtl/reg_alu_seq_decode.sv - combinational instruction decoder for reg_alu_seq
//
// Purpose: splits a 16-bit instruction word into class, ALU op, register
// addresses and immediate. Purely combinational; no state.
// Ports:
//   instr  in  16  instruction word
//   cls    out  2  instruction class
//   op     out  2  ALU operation (meaningful for ALU class)
//   rd     out  3  destination register (field position depends on class)
//   ra     out  3  ALU source A address
//   rb     out  3  ALU source B address
//   imm    out  8  LOADI immediate

module reg_alu_seq_decode
  import reg_alu_seq_pkg::*;
(
  input  logic [INSN_W-1:0] instr,
  output cls_e              cls,
  output logic [OP_W-1:0]   op,
  output logic [ADDR_W-1:0] rd,
  output logic [ADDR_W-1:0] ra,
  output logic [ADDR_W-1:0] rb,
  output logic [DATA_W-1:0] imm
);

  always_comb begin
    cls = cls_e'(instr[CLS_MSB:CLS_LSB]);
    op  = instr[ALU_OP_MSB:ALU_OP_LSB];
    ra  = instr[ALU_RA_MSB:ALU_RA_LSB];
    rb  = instr[ALU_RB_MSB:ALU_RB_LSB];
    imm = instr[IMM_MSB:IMM_LSB];
    // LOADI and ALU keep rd in different places; NOP/HALT ignore it.
    if (cls == CLS_LOADI) begin
      rd = instr[LOADI_RD_MSB:LOADI_RD_LSB];
    end else begin
      rd = instr[ALU_RD_MSB:ALU_RD_LSB];
    end
  end

endmodule

// File: rtl/reg_alu_seq.sv
// rtl/reg_alu_seq.sv - instruction sequencer driving reg_alu
//
// Purpose: accepts instructions over a valid/ready handshake, decodes them
// and drives reg_alu's controls for one EXEC cycle per instruction.
// Captures reg_alu carry on ALU instructions, counts retired instructions
// and stops accepting after a HALT until reset.
// Ports:
//   clk          in   1  rising-edge clock
//   reset        in   1  asynchronous active-low reset
//   in_valid     in   1  instruction offered
//   instr        in  16  instruction word
//   in_ready     out  1  sequencer can accept an instruction
//   cout         in   1  carry from reg_alu
//   sel          out  1  reg_alu write source: 1 ALU result, 0 d_in
//   wr           out  1  reg_alu write enable
//   op           out  2  reg_alu operation
//   rd_addr_a    out  3  reg_alu read address A
//   rd_addr_b    out  3  reg_alu read address B
//   wr_addr      out  3  reg_alu write address
//   d_in         out  8  immediate data to reg_alu
//   carry        out  1  last captured ALU carry
//   halted       out  1  HALT has retired
//   retired_cnt  out  8  retired instruction count, wraps

module reg_alu_seq
  import reg_alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [15:0] instr,
  output logic        in_ready,
  input  logic        cout,
  output logic        sel,
  output logic        wr,
  output logic [1:0]  op,
  output logic [2:0]  rd_addr_a,
  output logic [2:0]  rd_addr_b,
  output logic [2:0]  wr_addr,
  output logic [7:0]  d_in,
  output logic        carry,
  output logic        halted,
  output logic [7:0]  retired_cnt
);

  // Decoded fields of the offered instruction.
  cls_e              dec_cls;
  logic [OP_W-1:0]   dec_op;
  logic [ADDR_W-1:0] dec_rd;
  logic [ADDR_W-1:0] dec_ra;
  logic [ADDR_W-1:0] dec_rb;
  logic [DATA_W-1:0] dec_imm;

  reg_alu_seq_decode u_decode (
    .instr (instr),
    .cls   (dec_cls),
    .op    (dec_op),
    .rd    (dec_rd),
    .ra    (dec_ra),
    .rb    (dec_rb),
    .imm   (dec_imm)
  );

  // State and registered outputs.
  state_e            state_q,       state_d;
  cls_e              cls_q,         cls_d;
  logic              sel_q,         sel_d;
  logic              wr_q,          wr_d;
  logic [OP_W-1:0]   op_q,          op_d;
  logic [ADDR_W-1:0] rd_addr_a_q,   rd_addr_a_d;
  logic [ADDR_W-1:0] rd_addr_b_q,   rd_addr_b_d;
  logic [ADDR_W-1:0] wr_addr_q,     wr_addr_d;
  logic [DATA_W-1:0] d_in_q,        d_in_d;
  logic              carry_q,       carry_d;
  logic              halted_q,      halted_d;
  logic [7:0]        retired_cnt_q, retired_cnt_d;

  logic accept;

  assign accept = (state_q == IDLE) && in_valid;

  always_comb begin
    state_d       = state_q;
    cls_d         = cls_q;
    sel_d         = sel_q;
    wr_d          = 1'b0;
    op_d          = op_q;
    rd_addr_a_d   = rd_addr_a_q;
    rd_addr_b_d   = rd_addr_b_q;
    wr_addr_d     = wr_addr_q;
    d_in_d        = d_in_q;
    carry_d       = carry_q;
    halted_d      = halted_q;
    retired_cnt_d = retired_cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EXEC;
          cls_d   = dec_cls;
          wr_d    = cls_writes(dec_cls);
          // Only the controls the class uses are reloaded; the rest hold.
          case (dec_cls)
            CLS_LOADI: begin
              sel_d     = 1'b0;
              wr_addr_d = dec_rd;
              d_in_d    = dec_imm;
            end
            CLS_ALU: begin
              sel_d       = 1'b1;
              op_d        = dec_op;
              rd_addr_a_d = dec_ra;
              rd_addr_b_d = dec_rb;
              wr_addr_d   = dec_rd;
            end
            default: begin
            end
          endcase
        end
      end

      EXEC: begin
        // Retire: reg_alu performs the write at this same edge.
        retired_cnt_d = retired_cnt_q + 8'd1;
        if (cls_q == CLS_ALU) begin
          carry_d = cout;
        end
        if (cls_q == CLS_HALT) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      HALT: begin
        halted_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cls_q         <= CLS_NOP;
      sel_q         <= 1'b0;
      wr_q          <= 1'b0;
      op_q          <= '0;
      rd_addr_a_q   <= '0;
      rd_addr_b_q   <= '0;
      wr_addr_q     <= '0;
      d_in_q        <= '0;
      carry_q       <= 1'b0;
      halted_q      <= 1'b0;
      retired_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      cls_q         <= cls_d;
      sel_q         <= sel_d;
      wr_q          <= wr_d;
      op_q          <= op_d;
      rd_addr_a_q   <= rd_addr_a_d;
      rd_addr_b_q   <= rd_addr_b_d;
      wr_addr_q     <= wr_addr_d;
      d_in_q        <= d_in_d;
      carry_q       <= carry_d;
      halted_q      <= halted_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign sel         = sel_q;
  assign wr          = wr_q;
  assign op          = op_q;
  assign rd_addr_a   = rd_addr_a_q;
  assign rd_addr_b   = rd_addr_b_q;
  assign wr_addr     = wr_addr_q;
  assign d_in        = d_in_q;
  assign carry       = carry_q;
  assign halted      = halted_q;
  assign retired_cnt = retired_cnt_q;

endmodule

// File: tb/tb_reg_alu_seq.sv
// tb/tb_reg_alu_seq.sv - self-checking bench for reg_alu_seq with a reg_alu stand-in

module tb_reg_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] instr;
  logic        in_ready;
  logic        cout;
  logic        sel;
  logic        wr;
  logic [1:0]  op;
  logic [2:0]  rd_addr_a;
  logic [2:0]  rd_addr_b;
  logic [2:0]  wr_addr;
  logic [7:0]  d_in;
  logic        carry;
  logic        halted;
  logic [7:0]  retired_cnt;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  reg_alu_seq dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .instr       (instr),
    .in_ready    (in_ready),
    .cout        (cout),
    .sel         (sel),
    .wr          (wr),
    .op          (op),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .wr_addr     (wr_addr),
    .d_in        (d_in),
    .carry       (carry),
    .halted      (halted),
    .retired_cnt (retired_cnt)
  );

  // reg_alu stand-in: op 0 add, 1 subtract (carry = no borrow), 2 and, 3 or.
  function automatic logic [8:0] alu_f(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
    case (o)
      2'd0:    return {1'b0, a} + {1'b0, b};
      2'd1:    return {1'b0, a} + {1'b0, ~b} + 9'd1;
      2'd2:    return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  logic [7:0] env_regs [8];
  logic [8:0] alu_out;

  initial for (int i = 0; i < 8; i++) env_regs[i] = 8'h00;

  assign alu_out = alu_f(op, env_regs[rd_addr_a], env_regs[rd_addr_b]);
  assign cout    = alu_out[8];

  always @(posedge clk) begin
    if (wr) env_regs[wr_addr] <= sel ? alu_out[7:0] : d_in;
  end

  // Instruction builders; unused bits carry junk so the decoder must ignore them.
  function automatic logic [15:0] i_loadi(input logic [2:0] rd, input logic [7:0] imm);
    return {2'b00, rd, 3'b101, imm};
  endfunction
  function automatic logic [15:0] i_alu(input logic [1:0] o, input logic [2:0] rd,
                                        input logic [2:0] ra, input logic [2:0] rb);
    return {2'b01, o, rd, ra, rb, 3'b110};
  endfunction
  localparam logic [15:0] I_NOP  = 16'h8A5A;
  localparam logic [15:0] I_HALT = 16'hC3C3;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Architectural model: an instruction is either in flight (taken at one
  // handshake edge, retired at the next) or the sequencer is free/halted.
  logic       m_busy   = 1'b0;
  logic       m_halted = 1'b0;
  logic       m_carry  = 1'b0;
  logic [7:0] m_cnt    = 8'h00;
  logic [15:0] m_pend  = 16'h0000;
  logic [7:0] m_regs [8];

  initial for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy   = 1'b0;
      m_halted = 1'b0;
      m_carry  = 1'b0;
      m_cnt    = 8'h00;
    end else if (m_busy) begin
      logic [8:0] r;
      case (m_pend[15:14])
        2'b00: m_regs[m_pend[13:11]] = m_pend[7:0];
        2'b01: begin
          r = alu_f(m_pend[13:12], m_regs[m_pend[8:6]], m_regs[m_pend[5:3]]);
          m_regs[m_pend[11:9]] = r[7:0];
          m_carry = r[8];
        end
        2'b11: m_halted = 1'b1;
        default: ;
      endcase
      m_cnt  = m_cnt + 8'd1;
      m_busy = 1'b0;
    end else if (!m_halted && in_valid) begin
      m_pend = instr;
      m_busy = 1'b1;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    logic w_exp;
    w_exp = m_busy && (m_pend[15] == 1'b0);
    chk("in_ready", 32'(in_ready), 32'(!m_busy && !m_halted));
    chk("wr",       32'(wr),       32'(w_exp));
    chk("carry",    32'(carry),    32'(m_carry));
    chk("halted",   32'(halted),   32'(m_halted));
    chk("retired_cnt", 32'(retired_cnt), 32'(m_cnt));
    if (w_exp && m_pend[14] == 1'b0) begin
      chk("loadi_sel",     32'(sel),     0);
      chk("loadi_wr_addr", 32'(wr_addr), 32'(m_pend[13:11]));
      chk("loadi_d_in",    32'(d_in),    32'(m_pend[7:0]));
    end
    if (w_exp && m_pend[14] == 1'b1) begin
      chk("alu_sel",     32'(sel),       1);
      chk("alu_op",      32'(op),        32'(m_pend[13:12]));
      chk("alu_wr_addr", 32'(wr_addr),   32'(m_pend[11:9]));
      chk("alu_rd_a",    32'(rd_addr_a), 32'(m_pend[8:6]));
      chk("alu_rd_b",    32'(rd_addr_b), 32'(m_pend[5:3]));
    end
    for (int i = 0; i < 8; i++) chk("regfile", 32'(env_regs[i]), 32'(m_regs[i]));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Offer one instruction; returns 2 time units after the accepting edge.
  task automatic send(input logic [15:0] w);
    int  n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    instr    = w;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #2;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_mis++;
      $display("FAIL accept_timeout: got not accepted expected accepted instr %0h", w);
    end
  endtask

  task automatic do_reset();
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic check_reset_vals();
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_wr",       32'(wr),       0);
    chk("rst_sel",      32'(sel),      0);
    chk("rst_op",       32'(op),       0);
    chk("rst_rd_a",     32'(rd_addr_a), 0);
    chk("rst_rd_b",     32'(rd_addr_b), 0);
    chk("rst_wr_addr",  32'(wr_addr),  0);
    chk("rst_d_in",     32'(d_in),     0);
    chk("rst_carry",    32'(carry),    0);
    chk("rst_halted",   32'(halted),   0);
    chk("rst_cnt",      32'(retired_cnt), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    instr    = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    #1;
    reset = 1'b1;

    // LOADI R3 = 0x5A: one-cycle write with immediate source.
    send(i_loadi(3'd3, 8'h5A));
    chk("t1_wr",      32'(wr),      1);
    chk("t1_in_rdy",  32'(in_ready), 0);
    chk("t1_wr_addr", 32'(wr_addr), 3);
    chk("t1_d_in",    32'(d_in),    32'h5A);
    step();
    chk("t1_wr_off",  32'(wr),      0);
    chk("t1_r3",      32'(env_regs[3]), 32'h5A);
    chk("t1_cnt",     32'(retired_cnt), 1);

    // Back-to-back: R1=F0, R2=20, R4=R1+R2 -> 0x10 with carry.
    do_reset();
    send(i_loadi(3'd1, 8'hF0));
    send(i_loadi(3'd2, 8'h20));
    send(i_alu(2'd0, 3'd4, 3'd1, 3'd2));
    step();
    chk("t2_r4",    32'(env_regs[4]), 32'h10);
    chk("t2_carry", 32'(carry), 1);
    chk("t2_cnt",   32'(retired_cnt), 3);

    // Self-referencing add: R1 = F0 + F0 = 0x1E0.
    send(i_alu(2'd0, 3'd1, 3'd1, 3'd1));
    step();
    chk("t3_r1",    32'(env_regs[1]), 32'hE0);
    chk("t3_carry", 32'(carry), 1);
    chk("t3_cnt",   32'(retired_cnt), 4);

    // in_valid held through EXEC with a junk word that must not be taken.
    send(i_loadi(3'd6, 8'h11));
    in_valid = 1'b1;
    instr    = i_loadi(3'd6, 8'h99);
    step();
    send(i_alu(2'd0, 3'd7, 3'd6, 3'd3));
    step();
    chk("t4_r6",    32'(env_regs[6]), 32'h11);
    chk("t4_r7",    32'(env_regs[7]), 32'h6B);
    chk("t4_carry", 32'(carry), 0);
    chk("t4_cnt",   32'(retired_cnt), 6);

    // Subtract with borrow: R0 = 0x11 - 0x5A = 0xB7, carry 0.
    send(i_alu(2'd1, 3'd0, 3'd6, 3'd3));
    step();
    chk("t4b_r0",    32'(env_regs[0]), 32'hB7);
    chk("t4b_carry", 32'(carry), 0);

    // NOP, HALT, then a LOADI that must never be accepted.
    do_reset();
    send(I_NOP);
    chk("t5_nop_wr", 32'(wr), 0);
    step();
    chk("t5_nop_cnt", 32'(retired_cnt), 1);
    send(I_HALT);
    step();
    chk("t5_halted",  32'(halted), 1);
    chk("t5_cnt",     32'(retired_cnt), 2);
    in_valid = 1'b1;
    instr    = i_loadi(3'd0, 8'hEE);
    repeat (10) step();
    in_valid = 1'b0;
    chk("t5_in_rdy",  32'(in_ready), 0);
    chk("t5_r0",      32'(env_regs[0]), 32'hB7);

    // 256 NOPs wrap the retired count.
    do_reset();
    for (int i = 0; i < 256; i++) send(I_NOP);
    step();
    chk("t6_wrap", 32'(retired_cnt), 0);

    // Reset pulsed during EXEC of a LOADI: write lost, outputs at reset values.
    do_reset();
    send(i_loadi(3'd5, 8'h33));
    step();
    send(i_loadi(3'd5, 8'h77));
    #1;
    reset = 1'b0;
    #1;
    check_reset_vals();
    step();
    reset = 1'b1;
    step();
    step();
    chk("t7_r5",  32'(env_regs[5]), 32'h33);
    chk("t7_cnt", 32'(retired_cnt), 0);
    chk("t7_rdy", 32'(in_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
